reg_writeback: RTL

// - Write-side front end of the register file (regs). Buffers results from the ALU and load/memory paths.
// - Drives the single regs write port (w, Rd, w_data), one write per cycle.
// - Exports a per-register pending vector so decode can stall on outstanding writes.
// - Sits between the execute/memory stages and regs; regs read ports (Rs/Rd_data) are untouched.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 73 +++++++
 rtl/reg_writeback.sv | 105 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back front end.
package wb_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam int unsigned NUM_REGS = 32;
  localparam reg_addr_t   ZERO_REG = 5'd0;
  localparam int unsigned WB_N     = 8;

  typedef struct packed {
    reg_addr_t       rd;
    logic [WB_N-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t a);
    return NUM_REGS'(1) << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO holding pending register writes; exposes every slot and its
// valid bit so the top level can build the pending-register vector.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 13
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 din_i,
  output logic [W-1:0]                 dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic [DEPTH*W-1:0]           entries_o,
  output logic [DEPTH-1:0]             valid_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [DEPTH-1:0] valid_q;
  logic do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign valid_o = valid_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // Both gates use the state at cycle start, so a pop never frees a slot
  // for a push in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    entries_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entries_o[i*W +: W] = mem_q[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q]   <= din_i;
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Write-side front end of the register file: arbitrates ALU/load results into
// a FIFO and drains one write per cycle onto the regs write port.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int unsigned n     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  output logic                       alu_ready,
  input  logic [4:0]                 alu_rd,
  input  logic [n-1:0]               alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [4:0]                 mem_rd,
  input  logic [n-1:0]               mem_data,
  input  logic                       hold,
  output logic                       w,
  output logic [4:0]                 Rd,
  output logic [n-1:0]               w_data,
  output logic [31:0]                pending,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  typedef struct packed {
    reg_addr_t    rd;
    logic [n-1:0] data;
  } entry_t;

  localparam int unsigned EW = $bits(entry_t);

  entry_t           push_entry, head;
  logic             accept, push, pop, full, empty;
  logic [DEPTH*EW-1:0] entries;
  logic [DEPTH-1:0] valid;

  logic             w_q, w_d;
  reg_addr_t        rd_q, rd_d;
  logic [n-1:0]     data_q, data_d;

  // Load results are older instructions and always win the single push slot.
  always_comb begin
    mem_ready  = !reset && !full;
    alu_ready  = !reset && !full && !mem_valid;
    push_entry = mem_valid ? entry_t'{rd: mem_rd, data: mem_data}
                           : entry_t'{rd: alu_rd, data: alu_data};
    accept     = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    push       = accept && (push_entry.rd != ZERO_REG);
    pop        = !hold && !empty;
  end

  wb_fifo #(
    .DEPTH(DEPTH),
    .W    (EW)
  ) u_fifo (
    .clk_i    (clk),
    .reset_i  (reset),
    .push_i   (push),
    .pop_i    (pop),
    .din_i    (push_entry),
    .dout_o   (head),
    .full_o   (full),
    .empty_o  (empty),
    .count_o  (count),
    .entries_o(entries),
    .valid_o  (valid)
  );

  always_comb begin
    w_d    = pop;
    rd_d   = pop ? head.rd : '0;
    data_d = pop ? head.data : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q    <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
    end else begin
      w_q    <= w_d;
      rd_q   <= rd_d;
      data_q <= data_d;
    end
  end

  assign w      = w_q;
  assign Rd     = rd_q;
  assign w_data = data_q;

  always_comb begin
    entry_t slot;
    slot    = '0;
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = entries[i*EW +: EW];
      if (valid[i]) pending = pending | reg_onehot(slot.rd);
    end
    if (w_q) pending = pending | reg_onehot(rd_q);
    pending[0] = 1'b0;
  end

endmodule
